nx_stream_packer: RTL and testbench

Packetises the Nexus outbound control stream into framed AXI4-stream packets. Nexus emits a continuous message stream with no end-of-packet marker. This block sits between the mesh's `o_ctrl_out_*` port and the device-level outbound AXI4-stream, and it generates `tlast`. A packet ends on whichever comes first: a beat-count limit, an idle timeout, or an explicit flush. A one-beat holding stage delays each beat until its last flag is known.

---
 rtl/nx_stream_packer_if.sv | 20 ++
 rtl/nx_stream_packer.sv | 85 ++++++++
 tb/tb_nx_stream_packer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_stream_packer_if.sv
// nx_stream_packer_if: inbound message stream and outbound AXI4-stream bundle
interface nx_stream_packer_if #(
   parameter int DATA_WIDTH = 128
);
   logic [DATA_WIDTH-1:0] i_in_data;
   logic                  i_in_valid;
   logic                  o_in_ready;
   logic [DATA_WIDTH-1:0] o_out_data;
   logic                  o_out_last;
   logic                  o_out_valid;
   logic                  i_out_ready;
   modport slave (
      input  i_in_data, i_in_valid, i_out_ready,
      output o_in_ready, o_out_data, o_out_last, o_out_valid
   );
   modport master (
      output i_in_data, i_in_valid, i_out_ready,
      input  o_in_ready, o_out_data, o_out_last, o_out_valid
   );
endinterface

// File: rtl/nx_stream_packer.sv
// nx_stream_packer: frames a continuous message stream into tlast-delimited packets
module nx_stream_packer #(
   parameter int DATA_WIDTH = 128,
   parameter int MAX_BEATS  = 16,
   parameter int TIMEOUT    = 64
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   output logic                o_idle,
   nx_stream_packer_if.slave   io_bus
);
   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS - 1);
   localparam logic [TW-1:0] TMO     = TW'(TIMEOUT);
   logic                  r_h_valid;
   logic [DATA_WIDTH-1:0] r_h_data;
   logic [TW-1:0]         r_h_tmr;
   logic [CW-1:0]         r_beat_cnt;
   logic                  r_flush_pend;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_last;
   logic                  w_o_free;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_release;
   assign w_o_free   = !r_out_valid || io_bus.i_out_ready;
   assign w_in_ready = !i_rst && (!r_h_valid || w_o_free);
   assign w_accept   = io_bus.i_in_valid && w_in_ready;
   assign w_last     = (r_beat_cnt == CNT_MAX) || (r_h_tmr == TMO) || r_flush_pend || i_flush;
   assign w_release  = r_h_valid && w_o_free && (w_accept || w_last);
   assign io_bus.o_in_ready  = w_in_ready;
   assign io_bus.o_out_valid = r_out_valid;
   assign io_bus.o_out_data  = r_out_data;
   assign io_bus.o_out_last  = r_out_last;
   assign o_idle             = !r_h_valid && !r_out_valid;
   // Hold stage: capture accepted beats and age the held beat toward timeout
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_h_valid <= 1'b0;
         r_h_data  <= '0;
         r_h_tmr   <= '0;
      end else if (w_accept) begin
         r_h_valid <= 1'b1;
         r_h_data  <= io_bus.i_in_data;
         r_h_tmr   <= '0;
      end else if (w_release) begin
         r_h_valid <= 1'b0;
         r_h_tmr   <= '0;
      end else if (r_h_valid && r_h_tmr != TMO) begin
         r_h_tmr   <= r_h_tmr + 1'b1;
      end
   end
   // Packet position and pending flush; a flush with nothing to close is dropped
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_beat_cnt   <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         if (w_release)
            r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
         if (w_release)
            r_flush_pend <= 1'b0;
         else if (i_flush && (r_h_valid || w_accept))
            r_flush_pend <= 1'b1;
      end
   end
   // Output register: load on release, drop valid once consumed, hold while stalled
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_release) begin
         r_out_valid <= 1'b1;
         r_out_data  <= r_h_data;
         r_out_last  <= w_last;
      end else if (io_bus.i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_nx_stream_packer.sv
// tb_nx_stream_packer: directed vector table plus multi-cycle sequences for the stream packer
module tb_nx_stream_packer;
   localparam int DW = 128;
   localparam int MB = 16;
   localparam int TO = 64;
   typedef struct {
      logic [3:0] in;
      logic [7:0] d;
      logic [3:0] ex;
      logic [7:0] od;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic flush2 = 1'b0;
   logic idle, idle2;
   int n_chk = 0;
   int n_err = 0;
   vec_t tv[21];
   logic [DW-1:0] sb[$];
   nx_stream_packer_if #(.DATA_WIDTH(DW)) bus ();
   nx_stream_packer_if #(.DATA_WIDTH(DW)) bus2 ();
   nx_stream_packer #(.DATA_WIDTH(DW), .MAX_BEATS(MB), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .o_idle(idle), .io_bus(bus.slave)
   );
   nx_stream_packer #(.DATA_WIDTH(DW), .MAX_BEATS(1), .TIMEOUT(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush2), .o_idle(idle2), .io_bus(bus2.slave)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic vec_t mk(input logic [3:0] in, input logic [7:0] d, input logic [3:0] ex, input logic [7:0] od);
      vec_t v;
      v.in = in;
      v.d = d;
      v.ex = ex;
      v.od = od;
      return v;
   endfunction
   task automatic do_reset(input string tag);
      rst = 1'b1;
      flush = 1'b0;
      bus.i_in_valid = 1'b0;
      bus.i_out_ready = 1'b1;
      bus2.i_in_valid = 1'b0;
      bus2.i_out_ready = 1'b1;
      #1;
      chk({tag, " in_ready in reset"}, bus.o_in_ready, 0);
      tick();
      rst = 1'b0;
      chk({tag, " rst valid"}, bus.o_out_valid, 0);
      chk({tag, " rst last"}, bus.o_out_last, 0);
      chk({tag, " rst data"}, bus.o_out_data, 0);
      chk({tag, " rst idle"}, idle, 1);
   endtask
   task automatic run_burst(input int n);
      int nexp = 0;
      int lat = 0;
      int got_lat = -1;
      bus.i_out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.i_in_valid = 1'b1;
         bus.i_in_data = DW'(i);
         tick();
         if (bus.o_out_valid) begin
            chk("burst data", bus.o_out_data, nexp);
            chk("burst last", bus.o_out_last, ((nexp % MB) == MB - 1) || (nexp == n - 1));
            nexp++;
         end
      end
      bus.i_in_valid = 1'b0;
      while (nexp < n && lat < 200) begin
         tick();
         lat++;
         if (bus.o_out_valid) begin
            chk("burst data", bus.o_out_data, nexp);
            chk("burst last", bus.o_out_last, ((nexp % MB) == MB - 1) || (nexp == n - 1));
            nexp++;
            if (nexp == n) got_lat = lat;
         end
      end
      chk("burst beats out", nexp, n);
      chk("burst final latency", got_lat, (n % MB == 0) ? 1 : TO + 1);
   endtask
   initial begin
      int n, k, nout, left, unstable, cyc;
      bit started, have_ref;
      logic [DW-1:0] ref_d, exp_d;
      logic ref_l;
      bus.i_in_valid = 1'b0;
      bus.i_in_data = '0;
      bus.i_out_ready = 1'b1;
      bus2.i_in_valid = 1'b0;
      bus2.i_in_data = '0;
      bus2.i_out_ready = 1'b1;
      tick();
      tick();
      // in = {rst,vld,flush,ordy}; ex = {in_ready,out_valid,out_last,idle}
      tv[0]  = mk(4'b1001, 8'h00, 4'b0001, 8'h00);
      tv[1]  = mk(4'b0011, 8'h00, 4'b1001, 8'h00);
      tv[2]  = mk(4'b0101, 8'h01, 4'b1000, 8'h00);
      tv[3]  = mk(4'b0101, 8'h02, 4'b1100, 8'h01);
      tv[4]  = mk(4'b0101, 8'h03, 4'b1100, 8'h02);
      tv[5]  = mk(4'b0101, 8'h04, 4'b1100, 8'h03);
      tv[6]  = mk(4'b0101, 8'h05, 4'b1100, 8'h04);
      tv[7]  = mk(4'b0011, 8'h00, 4'b1110, 8'h05);
      tv[8]  = mk(4'b0001, 8'h00, 4'b1001, 8'h00);
      tv[9]  = mk(4'b0101, 8'h06, 4'b1000, 8'h00);
      tv[10] = mk(4'b0101, 8'h07, 4'b1100, 8'h06);
      tv[11] = mk(4'b0110, 8'h08, 4'b0100, 8'h06);
      tv[12] = mk(4'b0000, 8'h00, 4'b0100, 8'h06);
      tv[13] = mk(4'b0001, 8'h00, 4'b1110, 8'h07);
      tv[14] = mk(4'b0001, 8'h00, 4'b1001, 8'h00);
      tv[15] = mk(4'b0111, 8'h09, 4'b1000, 8'h00);
      tv[16] = mk(4'b0101, 8'h0A, 4'b1110, 8'h09);
      tv[17] = mk(4'b0111, 8'h0B, 4'b1110, 8'h0A);
      tv[18] = mk(4'b0001, 8'h00, 4'b1000, 8'h00);
      tv[19] = mk(4'b0011, 8'h00, 4'b1110, 8'h0B);
      tv[20] = mk(4'b0001, 8'h00, 4'b1001, 8'h00);
      for (int i = 0; i < 21; i++) begin
         rst = tv[i].in[3];
         bus.i_in_valid = tv[i].in[2];
         flush = tv[i].in[1];
         bus.i_out_ready = tv[i].in[0];
         bus.i_in_data = DW'(tv[i].d);
         #1;
         chk($sformatf("vec%0d in_ready", i), bus.o_in_ready, tv[i].ex[3]);
         tick();
         chk($sformatf("vec%0d out_valid", i), bus.o_out_valid, tv[i].ex[2]);
         chk($sformatf("vec%0d idle", i), idle, tv[i].ex[0]);
         if (tv[i].ex[2] || tv[i].in[3]) begin
            chk($sformatf("vec%0d out_last", i), bus.o_out_last, tv[i].ex[1]);
            chk($sformatf("vec%0d out_data", i), bus.o_out_data, DW'(tv[i].od));
         end
      end
      rst = 1'b0;
      flush = 1'b0;
      do_reset("count");
      run_burst(40);
      do_reset("timeout");
      bus.i_in_valid = 1'b1;
      bus.i_in_data = DW'(8'hA5);
      tick();
      bus.i_in_valid = 1'b0;
      n = 0;
      while (!bus.o_out_valid && n < 200) begin
         tick();
         n++;
      end
      chk("timeout edges", n, TO + 1);
      chk("timeout last", bus.o_out_last, 1);
      chk("timeout data", bus.o_out_data, 8'hA5);
      tick();
      chk("timeout idle after handshake", idle, 1);
      chk("timeout valid after handshake", bus.o_out_valid, 0);
      do_reset("backpressure");
      k = 0;
      nout = 0;
      left = 0;
      unstable = 0;
      started = 0;
      have_ref = 0;
      cyc = 0;
      while (nout < 20 && cyc < 1000) begin
         bus.i_out_ready = (left == 0);
         bus.i_in_valid = (k < 20);
         bus.i_in_data = DW'(k);
         #1;
         if (left == 1) begin
            chk("bp buffered beats", k - nout, 2);
            chk("bp in_ready stalled", bus.o_in_ready, 0);
         end
         if (bus.o_out_valid && bus.i_out_ready) begin
            chk("bp data", bus.o_out_data, nout);
            chk("bp last", bus.o_out_last, (nout == 5) || (nout == 19));
            nout++;
         end
         if (bus.o_out_valid && !bus.i_out_ready) begin
            if (have_ref && (bus.o_out_data !== ref_d || bus.o_out_last !== ref_l)) unstable++;
            ref_d = bus.o_out_data;
            ref_l = bus.o_out_last;
            have_ref = 1;
         end
         if (bus.i_in_valid && bus.o_in_ready) k++;
         tick();
         cyc++;
         if (left > 0) left--;
         if (!started && nout == 4) begin
            started = 1;
            left = 100;
         end
      end
      chk("bp beats out", nout, 20);
      chk("bp stall stability", unstable, 0);
      do_reset("midpkt pre");
      bus.i_out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus.i_in_valid = 1'b1;
         bus.i_in_data = DW'(8'h70 + i);
         tick();
      end
      do_reset("midpkt");
      run_burst(16);
      do_reset("mb1");
      for (int i = 0; i < 420; i++) begin
         if (i < 400) begin
            bus2.i_in_valid = 1'($urandom_range(0, 1));
            bus2.i_in_data = {$urandom, $urandom, $urandom, $urandom};
            bus2.i_out_ready = 1'($urandom_range(0, 1));
         end else begin
            bus2.i_in_valid = 1'b0;
            bus2.i_out_ready = 1'b1;
         end
         #1;
         if (bus2.o_out_valid && bus2.i_out_ready) begin
            if (sb.size() == 0) begin
               chk("mb1 unexpected beat", 1, 0);
            end else begin
               exp_d = sb.pop_front();
               chk("mb1 data", bus2.o_out_data, exp_d);
            end
            chk("mb1 last", bus2.o_out_last, 1);
         end
         if (bus2.i_in_valid && bus2.o_in_ready) sb.push_back(bus2.i_in_data);
         tick();
      end
      chk("mb1 scoreboard empty", sb.size(), 0);
      chk("mb1 idle", idle2, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
